// File: rtl/param_vending.sv
// Parameterised vending controller: coin credit, per-item stock, one-cycle vend,
// greedy dime/nickel change return and a done handshake.
module param_vending #(
  parameter int N_ITEMS    = 4,
  parameter int SEL_W      = 2,
  parameter int CREDIT_W   = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd40, 8'd30, 8'd20, 8'd15},
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic [SEL_W-1:0]    sel,
  input  logic                vend_req,
  input  logic                cancel,
  input  logic                restock,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [SEL_W-1:0]    item_out,
  output logic                ret_dime,
  output logic                ret_nickel,
  output logic                done,
  output logic                busy,
  output logic [N_ITEMS-1:0]  sold_out,
  output logic                reject_coin,
  output logic                err_funds,
  output logic                err_sold
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] VEND   = 2'd1;
  localparam logic [1:0] CHANGE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [CREDIT_W:0]   MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] FIVE  = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] TEN   = CREDIT_W'(10);

  logic [1:0]          state;
  logic [SEL_W-1:0]    sel_q;
  logic [STOCK_W-1:0]  stock [N_ITEMS];

  logic [2:0]          coin_vec;
  logic                coin_any;
  logic                coin_one;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   credit_sum;
  logic                coin_fits;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] q_price;
  logic                restock_now;

  assign coin_vec    = {quarter, dime, nickel};
  assign coin_any    = |coin_vec;
  assign coin_one    = coin_any && ((coin_vec & (coin_vec - 3'd1)) == 3'd0);
  assign credit_sum  = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits   = credit_sum <= MAX_C;
  assign busy        = (state != IDLE);
  assign restock_now = (state == IDLE) && !cancel && !vend_req && restock;

  // An out-of-range select never matches, so it reads as zero stock and is refused.
  always_comb begin
    coin_val  = '0;
    sel_stock = '0;
    sel_price = '0;
    q_price   = '0;
    sold_out  = '0;
    if (nickel)  coin_val = FIVE;
    if (dime)    coin_val = TEN;
    if (quarter) coin_val = CREDIT_W'(25);
    for (int i = 0; i < N_ITEMS; i++) begin
      sold_out[i] = (stock[i] == '0);
      if (sel == SEL_W'(i)) begin
        sel_stock = stock[i];
        sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
      if (sel_q == SEL_W'(i)) q_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      for (int i = 0; i < N_ITEMS; i++) begin
        if (restock_now)
          stock[i] <= STOCK_W'(STOCK_INIT);
        else if (state == VEND && sel_q == SEL_W'(i) && stock[i] != '0)
          stock[i] <= stock[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      credit      <= '0;
      sel_q       <= '0;
      item_out    <= '0;
      dispense    <= 1'b0;
      ret_dime    <= 1'b0;
      ret_nickel  <= 1'b0;
      done        <= 1'b0;
      reject_coin <= 1'b0;
      err_funds   <= 1'b0;
      err_sold    <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      ret_dime    <= 1'b0;
      ret_nickel  <= 1'b0;
      done        <= 1'b0;
      reject_coin <= 1'b0;
      err_funds   <= 1'b0;
      err_sold    <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel) begin
            reject_coin <= coin_any;
            if (credit != '0) state <= CHANGE;
          end else if (vend_req) begin
            reject_coin <= coin_any;
            if (sel_stock == '0)
              err_sold <= 1'b1;
            else if (credit < sel_price)
              err_funds <= 1'b1;
            else begin
              sel_q <= sel;
              state <= VEND;
            end
          end else if (restock) begin
            reject_coin <= coin_any;
          end else if (coin_any) begin
            if (coin_one && coin_fits) credit <= credit_sum[CREDIT_W-1:0];
            else                       reject_coin <= 1'b1;
          end
        end
        VEND: begin
          reject_coin <= coin_any;
          dispense    <= 1'b1;
          item_out    <= sel_q;
          credit      <= credit - q_price;
          state       <= (credit != q_price) ? CHANGE : DONE;
        end
        CHANGE: begin
          reject_coin <= coin_any;
          if (credit >= TEN) begin
            ret_dime <= 1'b1;
            credit   <= credit - TEN;
            if (credit == TEN) state <= DONE;
          end else if (credit >= FIVE) begin
            ret_nickel <= 1'b1;
            credit     <= credit - FIVE;
            if (credit == FIVE) state <= DONE;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          reject_coin <= coin_any;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_vending.sv
// Self-checking bench for param_vending: directed scenarios plus a randomized
// operation stream checked against a credit/stock reference model.
module tb_param_vending;

  logic       clk = 1'b0;
  logic       reset;
  logic       nickel, dime, quarter, vend_req, cancel, restock;
  logic [1:0] sel;
  logic [7:0] credit;
  logic       dispense, ret_dime, ret_nickel, done, busy;
  logic [1:0] item_out;
  logic [3:0] sold_out;
  logic       reject_coin, err_funds, err_sold;

  int checks   = 0;
  int failures = 0;
  int m_credit;
  int m_stock [4];
  int price   [4] = '{15, 20, 30, 40};

  param_vending dut (
    .clk(clk), .reset(reset), .nickel(nickel), .dime(dime), .quarter(quarter),
    .sel(sel), .vend_req(vend_req), .cancel(cancel), .restock(restock),
    .credit(credit), .dispense(dispense), .item_out(item_out),
    .ret_dime(ret_dime), .ret_nickel(ret_nickel), .done(done), .busy(busy),
    .sold_out(sold_out), .reject_coin(reject_coin), .err_funds(err_funds),
    .err_sold(err_sold)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    nickel = 0; dime = 0; quarter = 0; vend_req = 0; cancel = 0; restock = 0; sel = 2'd0;
  endtask

  // Hold inputs across one active edge; outputs afterwards reflect that edge.
  task automatic drive(input logic n, input logic d, input logic q, input logic v,
                       input logic c, input logic r, input logic [1:0] s);
    nickel = n; dime = d; quarter = q; vend_req = v; cancel = c; restock = r; sel = s;
    step();
    clear_in();
  endtask

  task automatic hard_reset();
    clear_in();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 3;
  endtask

  // Runs until the done pulse (or the cycle budget), tallying output pulses.
  task automatic collect(input int max_cyc, output int n_disp, output int item,
                         output int n_dime, output int n_nick, output int disp_at,
                         output int first_coin_at, output int done_at);
    n_disp = 0; item = -1; n_dime = 0; n_nick = 0;
    disp_at = -1; first_coin_at = -1; done_at = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      if (dispense) begin
        n_disp++;
        item = int'(item_out);
        if (disp_at < 0) disp_at = c;
      end
      if (ret_dime) n_dime++;
      if (ret_nickel) n_nick++;
      if ((ret_dime || ret_nickel) && first_coin_at < 0) first_coin_at = c;
      if (done) begin
        done_at = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b0;
    #12;
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_state: credit=%0d busy=%0d expected 0/0", credit, busy);
    end
    checks++;
    if ({dispense, ret_dime, ret_nickel, done, reject_coin, err_funds, err_sold} !== 7'd0 ||
        item_out !== 2'd0 || sold_out !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: pulses=%b item_out=%0d sold_out=%b expected all 0",
               {dispense, ret_dime, ret_nickel, done, reject_coin, err_funds, err_sold}, item_out, sold_out);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    checks++;
    if (credit !== 8'd5) begin
      failures++; $display("[TB] FAIL first_coin_after_reset: credit=%0d expected 5", credit);
    end
  endtask

  task automatic test_dime_dime_item0();
    int nd, it, ndm, nn, da, fc, dn;
    hard_reset();
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    checks++;
    if (credit !== 8'd20) begin
      failures++; $display("[TB] FAIL dd_credit: credit=%0d expected 20", credit);
    end
    drive(0, 0, 0, 1, 0, 0, 2'd0);
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("[TB] FAIL dd_busy_vend: busy=%0d expected 1", busy);
    end
    collect(20, nd, it, ndm, nn, da, fc, dn);
    checks++;
    if (nd != 1 || it != 0 || da != 1) begin
      failures++; $display("[TB] FAIL dd_dispense: count=%0d item=%0d at=%0d expected 1/0/1", nd, it, da);
    end
    checks++;
    if (ndm != 0 || nn != 1 || fc != 2 || dn != 3) begin
      failures++;
      $display("[TB] FAIL dd_change: dimes=%0d nickels=%0d first=%0d done=%0d expected 0/1/2/3", ndm, nn, fc, dn);
    end
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0) begin
      failures++; $display("[TB] FAIL dd_final: credit=%0d busy=%0d expected 0/0", credit, busy);
    end
  endtask

  task automatic test_sixty_item3();
    int nd, it, ndm, nn, da, fc, dn;
    hard_reset();
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    checks++;
    if (credit !== 8'd60) begin
      failures++; $display("[TB] FAIL qqd_credit: credit=%0d expected 60", credit);
    end
    drive(0, 0, 0, 1, 0, 0, 2'd3);
    collect(20, nd, it, ndm, nn, da, fc, dn);
    checks++;
    if (nd != 1 || it != 3 || da != 1) begin
      failures++; $display("[TB] FAIL qqd_dispense: count=%0d item=%0d at=%0d expected 1/3/1", nd, it, da);
    end
    checks++;
    if (ndm != 2 || nn != 0 || fc != 2 || dn != 4 || credit !== 8'd0) begin
      failures++;
      $display("[TB] FAIL qqd_change: dimes=%0d nickels=%0d first=%0d done=%0d credit=%0d expected 2/0/2/4/0",
               ndm, nn, fc, dn, credit);
    end
  endtask

  task automatic test_funds_cancel();
    int nd, it, ndm, nn, da, fc, dn;
    hard_reset();
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    drive(0, 0, 0, 1, 0, 0, 2'd1);
    checks++;
    if (err_funds !== 1'b1 || err_sold !== 1'b0 || credit !== 8'd5 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL funds_err: err_funds=%0d err_sold=%0d credit=%0d busy=%0d expected 1/0/5/0",
               err_funds, err_sold, credit, busy);
    end
    drive(0, 0, 0, 0, 1, 0, 2'd0);
    collect(20, nd, it, ndm, nn, da, fc, dn);
    checks++;
    if (nd != 0 || ndm != 0 || nn != 1 || dn != 2 || credit !== 8'd0) begin
      failures++;
      $display("[TB] FAIL funds_cancel: disp=%0d dimes=%0d nickels=%0d done=%0d credit=%0d expected 0/0/1/2/0",
               nd, ndm, nn, dn, credit);
    end
  endtask

  task automatic test_sold_out_restock();
    int nd, it, ndm, nn, da, fc, dn;
    hard_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 0, 2'd0);
      drive(1, 0, 0, 0, 0, 0, 2'd0);
      drive(0, 0, 0, 1, 0, 0, 2'd0);
      collect(20, nd, it, ndm, nn, da, fc, dn);
      checks++;
      if (nd != 1 || it != 0 || ndm + nn != 0 || dn != 2) begin
        failures++;
        $display("[TB] FAIL exact15_%0d: disp=%0d item=%0d coins=%0d done=%0d expected 1/0/0/2", k, nd, it, ndm + nn, dn);
      end
    end
    checks++;
    if (sold_out !== 4'b0001) begin
      failures++; $display("[TB] FAIL sold_out_set: sold_out=%b expected 0001", sold_out);
    end
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    drive(0, 0, 0, 1, 0, 0, 2'd0);
    checks++;
    if (err_sold !== 1'b1 || err_funds !== 1'b0 || credit !== 8'd15 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sold_err: err_sold=%0d err_funds=%0d credit=%0d busy=%0d expected 1/0/15/0",
               err_sold, err_funds, credit, busy);
    end
    // A refill pulsed while change is being returned must not take effect.
    drive(0, 0, 0, 0, 1, 0, 2'd0);
    drive(0, 0, 0, 0, 0, 1, 2'd0);
    collect(20, nd, it, ndm, nn, da, fc, dn);
    checks++;
    if (sold_out !== 4'b0001 || credit !== 8'd0) begin
      failures++; $display("[TB] FAIL restock_busy_ignored: sold_out=%b credit=%0d expected 0001/0", sold_out, credit);
    end
    drive(0, 0, 0, 0, 0, 1, 2'd0);
    checks++;
    if (sold_out !== 4'b0000) begin
      failures++; $display("[TB] FAIL restock_idle: sold_out=%b expected 0000", sold_out);
    end
  endtask

  task automatic test_reject();
    int nd, it, ndm, nn, da, fc, dn;
    hard_reset();
    for (int k = 0; k < 3; k++) drive(0, 0, 1, 0, 0, 0, 2'd0);
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    drive(1, 0, 0, 0, 0, 0, 2'd0);
    checks++;
    if (credit !== 8'd90) begin
      failures++; $display("[TB] FAIL rej_build: credit=%0d expected 90", credit);
    end
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    checks++;
    if (reject_coin !== 1'b1 || credit !== 8'd90) begin
      failures++; $display("[TB] FAIL rej_over_max: reject=%0d credit=%0d expected 1/90", reject_coin, credit);
    end
    drive(1, 1, 0, 0, 0, 0, 2'd0);
    checks++;
    if (reject_coin !== 1'b1 || credit !== 8'd90) begin
      failures++; $display("[TB] FAIL rej_multi: reject=%0d credit=%0d expected 1/90", reject_coin, credit);
    end
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    checks++;
    if (reject_coin !== 1'b0 || credit !== 8'd100) begin
      failures++; $display("[TB] FAIL rej_fill_max: reject=%0d credit=%0d expected 0/100", reject_coin, credit);
    end
    drive(0, 1, 0, 0, 0, 1, 2'd0);
    checks++;
    if (reject_coin !== 1'b1 || credit !== 8'd100) begin
      failures++; $display("[TB] FAIL rej_with_restock: reject=%0d credit=%0d expected 1/100", reject_coin, credit);
    end
    drive(0, 0, 0, 0, 1, 0, 2'd0);
    drive(0, 0, 1, 0, 0, 0, 2'd0);
    checks++;
    if (reject_coin !== 1'b1 || ret_dime !== 1'b1 || credit !== 8'd90) begin
      failures++;
      $display("[TB] FAIL rej_in_change: reject=%0d ret_dime=%0d credit=%0d expected 1/1/90", reject_coin, ret_dime, credit);
    end
    collect(30, nd, it, ndm, nn, da, fc, dn);
    checks++;
    if (ndm != 9 || nn != 0 || dn != 10 || credit !== 8'd0) begin
      failures++;
      $display("[TB] FAIL rej_refund: dimes=%0d nickels=%0d done=%0d credit=%0d expected 9/0/10/0", ndm, nn, dn, credit);
    end
  endtask

  task automatic test_reset_mid_change();
    int nd, it, ndm, nn, da, fc, dn;
    int stray;
    hard_reset();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 2'd0);
      drive(0, 1, 0, 0, 0, 0, 2'd0);
      drive(1, 0, 0, 0, 0, 0, 2'd0);
      drive(0, 0, 0, 1, 0, 0, 2'd0);
      collect(20, nd, it, ndm, nn, da, fc, dn);
    end
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    drive(0, 1, 0, 0, 0, 0, 2'd0);
    drive(0, 0, 0, 0, 1, 0, 2'd0);
    checks++;
    if (credit !== 8'd20 || busy !== 1'b1 || sold_out !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL midrst_pre: credit=%0d busy=%0d sold_out=%b expected 20/1/0001", credit, busy, sold_out);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (credit !== 8'd0 || busy !== 1'b0 || sold_out !== 4'b0000 || ret_dime !== 1'b0 || ret_nickel !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_async: credit=%0d busy=%0d sold_out=%b ret=%b%b expected 0/0/0000/00",
               credit, busy, sold_out, ret_dime, ret_nickel);
    end
    stray = 0;
    repeat (3) begin
      step();
      if (ret_dime || ret_nickel || done) stray++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      step();
      if (ret_dime || ret_nickel || done || busy) stray++;
    end
    checks++;
    if (stray != 0 || credit !== 8'd0) begin
      failures++; $display("[TB] FAIL midrst_after: stray_cycles=%0d credit=%0d expected 0/0", stray, credit);
    end
  endtask

  task automatic test_random_ops();
    int nd, it, ndm, nn, da, fc, dn;
    int op, k, v, s, mk, change, ecoins;
    int masks [4] = '{3, 5, 6, 7};
    logic [3:0] exp_so;
    logic exp_rej;
    hard_reset();
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        k = $urandom_range(0, 2);
        v = (k == 0) ? 5 : (k == 1) ? 10 : 25;
        exp_rej = (m_credit + v > 100);
        if (!exp_rej) m_credit += v;
        drive(k == 0, k == 1, k == 2, 0, 0, 0, 2'd0);
        checks++;
        if (reject_coin !== exp_rej || credit !== 8'(m_credit)) begin
          failures++;
          $display("[TB] FAIL rnd_coin[%0d]: reject=%0d credit=%0d expected %0d/%0d", n, reject_coin, credit, exp_rej, m_credit);
        end
      end else if (op == 4) begin
        mk = masks[$urandom_range(0, 3)];
        drive(mk[0], mk[1], mk[2], 0, 0, 0, 2'd0);
        checks++;
        if (reject_coin !== 1'b1 || credit !== 8'(m_credit)) begin
          failures++;
          $display("[TB] FAIL rnd_multi[%0d]: reject=%0d credit=%0d expected 1/%0d", n, reject_coin, credit, m_credit);
        end
      end else if (op <= 7) begin
        s = $urandom_range(0, 3);
        drive(0, 0, 0, 1, 0, 0, 2'(s));
        if (m_stock[s] == 0) begin
          checks++;
          if (err_sold !== 1'b1 || err_funds !== 1'b0 || busy !== 1'b0 || credit !== 8'(m_credit)) begin
            failures++;
            $display("[TB] FAIL rnd_sold[%0d]: err_sold=%0d err_funds=%0d busy=%0d credit=%0d expected 1/0/0/%0d",
                     n, err_sold, err_funds, busy, credit, m_credit);
          end
        end else if (m_credit < price[s]) begin
          checks++;
          if (err_funds !== 1'b1 || err_sold !== 1'b0 || busy !== 1'b0 || credit !== 8'(m_credit)) begin
            failures++;
            $display("[TB] FAIL rnd_funds[%0d]: err_funds=%0d err_sold=%0d busy=%0d credit=%0d expected 1/0/0/%0d",
                     n, err_funds, err_sold, busy, credit, m_credit);
          end
        end else begin
          change = m_credit - price[s];
          ecoins = change / 10 + (change % 10) / 5;
          collect(30, nd, it, ndm, nn, da, fc, dn);
          checks++;
          if (nd != 1 || it != s || da != 1 || ndm != change / 10 || nn != (change % 10) / 5 ||
              dn != 2 + ecoins || credit !== 8'd0) begin
            failures++;
            $display("[TB] FAIL rnd_vend[%0d]: disp=%0d item=%0d at=%0d dimes=%0d nickels=%0d done=%0d credit=%0d expected 1/%0d/1/%0d/%0d/%0d/0",
                     n, nd, it, da, ndm, nn, dn, credit, s, change / 10, (change % 10) / 5, 2 + ecoins);
          end
          m_credit = 0;
          m_stock[s]--;
        end
      end else if (op == 8) begin
        drive(0, 0, 0, 0, 1, 0, 2'd0);
        if (m_credit == 0) begin
          checks++;
          if (busy !== 1'b0 || credit !== 8'd0) begin
            failures++; $display("[TB] FAIL rnd_cancel_empty[%0d]: busy=%0d credit=%0d expected 0/0", n, busy, credit);
          end
        end else begin
          ecoins = m_credit / 10 + (m_credit % 10) / 5;
          collect(30, nd, it, ndm, nn, da, fc, dn);
          checks++;
          if (nd != 0 || ndm != m_credit / 10 || nn != (m_credit % 10) / 5 || dn != 1 + ecoins || credit !== 8'd0) begin
            failures++;
            $display("[TB] FAIL rnd_cancel[%0d]: disp=%0d dimes=%0d nickels=%0d done=%0d credit=%0d expected 0/%0d/%0d/%0d/0",
                     n, nd, ndm, nn, dn, credit, m_credit / 10, (m_credit % 10) / 5, 1 + ecoins);
          end
          m_credit = 0;
        end
      end else begin
        drive(0, 0, 0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 4; i++) m_stock[i] = 3;
      end
      for (int i = 0; i < 4; i++) exp_so[i] = (m_stock[i] == 0);
      checks++;
      if (sold_out !== exp_so) begin
        failures++; $display("[TB] FAIL rnd_sold_out[%0d]: sold_out=%b expected %b", n, sold_out, exp_so);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dime_dime_item0();
    test_sixty_item3();
    test_funds_cancel();
    test_sold_out_restock();
    test_reject();
    test_reset_mid_change();
    test_random_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_vending.md
PARAM_VENDING -- requirements
Module: param_vending

Interface
REQ-001 The parameters SHALL be: N_ITEMS, default 4, number of products.
REQ-002 SEL_W, default 2, product-select width, at least clog2(N_ITEMS).
REQ-003 CREDIT_W, default 8, credit and price width in cents.
REQ-004 PRICES, default {8'd40,8'd30,8'd20,8'd15}, packed N_ITEMS*CREDIT_W price table, item i at bits [i*CREDIT_W +: CREDIT_W]; every price is a nonzero multiple of 5.
REQ-005 MAX_CREDIT, default 100, credit ceiling, a multiple of 5.
REQ-006 STOCK_W, default 4, and STOCK_INIT, default 3, per-item stock counter width and refill value.
REQ-007 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- nickel / dime / quarter, in, 1 each, coin strobes worth 5 / 10 / 25 cents.
- sel, in, SEL_W, product select.
- vend_req, in, 1, purchase request.
- cancel, in, 1, refund request.
- restock, in, 1, refill all stock.
- credit, out, CREDIT_W, current credit.
- dispense, out, 1, one-cycle vend pulse.
- item_out, out, SEL_W, item being dispensed.
- ret_dime / ret_nickel, out, 1 each, one-cycle change-coin pulses.
- done, out, 1, one-cycle transaction-complete pulse.
- busy, out, 1, high whenever state is not IDLE.
- sold_out, out, N_ITEMS, bit i high when stock[i] == 0.
- reject_coin / err_funds / err_sold, out, 1 each, one-cycle error pulses.

Function
REQ-008 All outputs SHALL be registered, except that busy and sold_out may be decoded directly from registered state.
REQ-009 The FSM SHALL have the states IDLE, VEND, CHANGE and DONE; event priority in IDLE is cancel > vend_req > restock > coin.
REQ-010 IDLE coin handling: if exactly one strobe is high and credit+value <= MAX_CREDIT, then credit += value on the next edge.
REQ-011 IDLE coin rejection: multiple strobes, a value that would exceed MAX_CREDIT, or a coin arriving in the same cycle as cancel, vend_req or restock SHALL raise reject_coin for one cycle and leave credit unchanged.
REQ-012 IDLE cancel: if credit > 0, go to CHANGE with the full credit as the refund; if credit == 0, stay in IDLE with no pulse.
REQ-013 IDLE vend_req: if sel >= N_ITEMS or stock[sel] == 0, raise err_sold; else if credit < price[sel], raise err_funds; in both cases stay in IDLE with credit unchanged.
REQ-014 IDLE vend_req, valid purchase: latch sel and go to VEND.
REQ-015 IDLE restock SHALL set every stock counter to STOCK_INIT; restock outside IDLE SHALL be ignored.
REQ-016 VEND SHALL last exactly one cycle and, on its exit edge:
- assert dispense with item_out set to the latched sel;
- decrement stock[sel];
- set credit to credit - price;
- go to CHANGE if the new credit > 0, else to DONE.
REQ-017 CHANGE SHALL emit one coin per cycle, greedy:
- credit >= 10: pulse ret_dime, credit -= 10;
- else: pulse ret_nickel, credit -= 5;
- go to DONE on the cycle credit reaches 0.
REQ-018 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-019 Latency: vend_req to dispense is one cycle; dispense to the first change coin is one cycle; the last coin to done is one cycle.
REQ-020 Outside IDLE, any coin strobe SHALL raise reject_coin, and vend_req, cancel and restock SHALL be ignored.
REQ-021 Credit SHALL never exceed MAX_CREDIT, never go negative and never wrap; stock SHALL never decrement below 0.

Reset
REQ-022 Reset low SHALL immediately force the following, including mid-transaction: state IDLE, credit 0, every stock counter STOCK_INIT, and all pulse outputs and item_out 0; any in-progress change is discarded.
REQ-023 After reset deasserts, the first accepted coin SHALL take effect on the first rising clk edge.

Verification
REQ-024 Dime, dime, then vend_req sel=0 -> credit 20; dispense with item_out=0; one ret_nickel; done; credit 0; stock[0]=2.
REQ-025 Quarter, quarter, dime, then vend_req sel=3 -> credit 60; dispense; ret_dime on two consecutive cycles; done; credit 0.
REQ-026 Nickel, then vend_req sel=1 -> err_funds pulse with credit still 5; then cancel -> one ret_nickel, done, credit 0.
REQ-027 Three exact-15 purchases of item 0, then a fourth request -> err_sold pulse with sold_out[0]=1; then restock -> sold_out[0]=0.
REQ-028 Credit 90 plus quarter -> reject_coin with credit 90; nickel and dime together -> reject_coin; coin during CHANGE -> reject_coin.
REQ-029 Reset low during CHANGE with credit 20 -> credit 0, busy 0, no further ret pulses, stock restored to STOCK_INIT.
